// File: rtl/mprc_dcache_pkg.sv
// Shared D-cache geometry and writeback-reader state encoding.
// Also holds the victim-way select helper.
package mprc_dcache_pkg;

    localparam int ROW_BITS      = 128;
    localparam int ROWS_PER_LINE = 4;
    localparam int IDX_BITS      = 6;
    localparam int TAG_BITS      = 20;
    localparam int ROW_OFF_BITS  = 4;
    localparam int NWAYS         = 4;
    localparam int ROW_SEL_BITS  = $clog2(ROWS_PER_LINE);
    localparam int ADDR_BITS     = IDX_BITS + ROW_SEL_BITS + ROW_OFF_BITS;

    typedef enum logic {
        WB_IDLE   = 1'b0,
        WB_ACTIVE = 1'b1
    } wb_state_e;

    // Index of the lowest set bit; a malformed (non one-hot) way_en still selects deterministically.
    function automatic logic [1:0] lowest_way(input logic [NWAYS-1:0] way_en);
        lowest_way = 2'd0;
        for (int unsigned i = 0; i < NWAYS; i++) begin
            if (way_en[NWAYS-1-i]) lowest_way = 2'(NWAYS-1-i);
        end
    endfunction

endpackage

// File: rtl/mprc_wb_row_fifo.sv
// Small synchronous row buffer between data-array capture and the release channel.
// Head entry is presented combinationally; reset flushes all pointers.
module mprc_wb_row_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 128
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/mprc_wb_line_reader.sv
// Writeback line reader: reads a victim line row by row from the data array
// and streams it as release beats through a small row buffer.
module mprc_wb_line_reader
    import mprc_dcache_pkg::*;
#(
    parameter int FIFO_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_req_valid,
    output logic                 io_req_ready,
    input  logic [5:0]           io_req_bits_idx,
    input  logic [3:0]           io_req_bits_way_en,
    input  logic [19:0]          io_req_bits_tag,
    output logic                 io_data_req_valid,
    input  logic                 io_data_req_ready,
    output logic [3:0]           io_data_req_bits_way_en,
    output logic [11:0]          io_data_req_bits_addr,
    input  logic [127:0]         io_data_resp_0,
    input  logic [127:0]         io_data_resp_1,
    input  logic [127:0]         io_data_resp_2,
    input  logic [127:0]         io_data_resp_3,
    output logic                 io_release_valid,
    input  logic                 io_release_ready,
    output logic [127:0]         io_release_bits_data,
    output logic [1:0]           io_release_bits_beat,
    output logic                 io_release_bits_last,
    output logic [19:0]          io_release_bits_tag,
    output logic                 io_busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    wb_state_e             state, state_nxt;
    logic [2:0]            rd_cnt, wr_cnt;
    logic                  inflight;
    logic [IDX_BITS-1:0]   idx_q;
    logic [NWAYS-1:0]      way_q;
    logic [TAG_BITS-1:0]   tag_q;
    logic                  req_fire, rd_fire, rel_fire;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [CNT_W:0]        occupancy;
    logic [ROW_BITS-1:0]   resp_sel;

    assign req_fire  = io_req_valid & io_req_ready;
    assign rd_fire   = io_data_req_valid & io_data_req_ready;
    assign rel_fire  = io_release_valid & io_release_ready;
    // Rows already buffered plus the one still on its way back from the array.
    assign occupancy = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, inflight};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WB_IDLE;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            inflight <= 1'b0;
            idx_q    <= '0;
            way_q    <= '0;
            tag_q    <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_fire;
            if (req_fire) begin
                idx_q  <= io_req_bits_idx;
                way_q  <= io_req_bits_way_en;
                tag_q  <= io_req_bits_tag;
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (rd_fire)  rd_cnt <= rd_cnt + 3'd1;
                if (rel_fire) wr_cnt <= wr_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        io_req_ready      = 1'b0;
        io_busy           = 1'b0;
        io_data_req_valid = 1'b0;
        case (state)
            WB_IDLE: begin
                io_req_ready = 1'b1;
                if (io_req_valid) state_nxt = WB_ACTIVE;
            end
            WB_ACTIVE: begin
                io_busy           = 1'b1;
                io_data_req_valid = (rd_cnt < 3'(ROWS_PER_LINE)) &&
                                    (occupancy < (CNT_W+1)'(FIFO_DEPTH));
                if (rel_fire && io_release_bits_last) state_nxt = WB_IDLE;
            end
            default: state_nxt = WB_IDLE;
        endcase
    end

    always_comb begin
        resp_sel = io_data_resp_0;
        case (lowest_way(way_q))
            2'd0:    resp_sel = io_data_resp_0;
            2'd1:    resp_sel = io_data_resp_1;
            2'd2:    resp_sel = io_data_resp_2;
            default: resp_sel = io_data_resp_3;
        endcase
    end

    assign io_data_req_bits_way_en = way_q;
    assign io_data_req_bits_addr   = {idx_q, rd_cnt[ROW_SEL_BITS-1:0], {ROW_OFF_BITS{1'b0}}};

    mprc_wb_row_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ROW_BITS)
    ) u_row_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (resp_sel),
        .pop       (rel_fire),
        .head      (io_release_bits_data),
        .count     (fifo_cnt)
    );

    assign io_release_valid     = (fifo_cnt != '0);
    assign io_release_bits_beat = wr_cnt[1:0];
    assign io_release_bits_last = (wr_cnt == 3'(ROWS_PER_LINE - 1));
    assign io_release_bits_tag  = tag_q;

    a_way_onehot: assert property (@(posedge clk) disable iff (reset)
        req_fire |-> $onehot(io_req_bits_way_en));

endmodule

// File: tb/tb_mprc_wb_line_reader.sv
// Scoreboard bench for mprc_wb_line_reader: a memory-image model predicts every
// read address and release beat; a monitor compares whatever the DUT presents.
module tb_mprc_wb_line_reader;

    logic          clk = 1'b0;
    logic          reset;
    logic          io_req_valid;
    logic          io_req_ready;
    logic [5:0]    io_req_bits_idx;
    logic [3:0]    io_req_bits_way_en;
    logic [19:0]   io_req_bits_tag;
    logic          io_data_req_valid;
    logic          io_data_req_ready;
    logic [3:0]    io_data_req_bits_way_en;
    logic [11:0]   io_data_req_bits_addr;
    logic [127:0]  resp [4];
    logic          io_release_valid;
    logic          io_release_ready;
    logic [127:0]  io_release_bits_data;
    logic [1:0]    io_release_bits_beat;
    logic          io_release_bits_last;
    logic [19:0]   io_release_bits_tag;
    logic          io_busy;

    mprc_wb_line_reader #(.FIFO_DEPTH(3)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .io_req_valid            (io_req_valid),
        .io_req_ready            (io_req_ready),
        .io_req_bits_idx         (io_req_bits_idx),
        .io_req_bits_way_en      (io_req_bits_way_en),
        .io_req_bits_tag         (io_req_bits_tag),
        .io_data_req_valid       (io_data_req_valid),
        .io_data_req_ready       (io_data_req_ready),
        .io_data_req_bits_way_en (io_data_req_bits_way_en),
        .io_data_req_bits_addr   (io_data_req_bits_addr),
        .io_data_resp_0          (resp[0]),
        .io_data_resp_1          (resp[1]),
        .io_data_resp_2          (resp[2]),
        .io_data_resp_3          (resp[3]),
        .io_release_valid        (io_release_valid),
        .io_release_ready        (io_release_ready),
        .io_release_bits_data    (io_release_bits_data),
        .io_release_bits_beat    (io_release_bits_beat),
        .io_release_bits_last    (io_release_bits_last),
        .io_release_bits_tag     (io_release_bits_tag),
        .io_busy                 (io_busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Data-array image: mem[way][{idx,row}]
    logic [127:0] mem [4][256];

    typedef struct {
        logic [127:0] data;
        logic [1:0]   beat;
        logic         last;
        logic [19:0]  tag;
    } beat_t;
    typedef struct {
        logic [11:0] addr;
        logic [3:0]  way;
    } rd_t;

    beat_t exp_beats[$];
    rd_t   exp_rds[$];

    logic        rd_fire_seen = 1'b0;
    logic [11:0] rd_addr_seen = '0;
    logic        prev_rd_stall = 1'b0;
    int unsigned rd_fire_total = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Data array: correct rows only in the cycle after a read fire, garbage otherwise.
    initial begin
        for (int n = 0; n < 4; n++) resp[n] = '0;
        forever begin
            @(negedge clk);
            for (int n = 0; n < 4; n++)
                resp[n] = rd_fire_seen ? mem[n][rd_addr_seen[11:4]] : rnd128();
        end
    end

    // Monitor: compares presented read requests and release beats to the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                exp_beats.delete();
                exp_rds.delete();
                rd_fire_seen  = 1'b0;
                prev_rd_stall = 1'b0;
            end else begin
                if (prev_rd_stall) chk("rd_valid_held", 128'(io_data_req_valid), 128'(1));
                rd_fire_seen = 1'b0;
                if (io_data_req_valid) begin
                    if (exp_rds.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL rd_unexpected: got addr %h expected no read (cycle %0d)",
                                 io_data_req_bits_addr, cyc);
                    end else begin
                        chk("rd_addr", 128'(io_data_req_bits_addr), 128'(exp_rds[0].addr));
                        chk("rd_way", 128'(io_data_req_bits_way_en), 128'(exp_rds[0].way));
                        if (io_data_req_ready) begin
                            rd_fire_seen = 1'b1;
                            rd_addr_seen = io_data_req_bits_addr;
                            rd_fire_total++;
                            void'(exp_rds.pop_front());
                        end
                    end
                end
                prev_rd_stall = io_data_req_valid && !io_data_req_ready;
                if (io_release_valid) begin
                    if (exp_beats.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL rel_unexpected: got beat %0d expected no beat (cycle %0d)",
                                 io_release_bits_beat, cyc);
                    end else begin
                        chk("rel_data", io_release_bits_data, exp_beats[0].data);
                        chk("rel_beat", 128'(io_release_bits_beat), 128'(exp_beats[0].beat));
                        chk("rel_last", 128'(io_release_bits_last), 128'(exp_beats[0].last));
                        chk("rel_tag", 128'(io_release_bits_tag), 128'(exp_beats[0].tag));
                        if (io_release_ready) void'(exp_beats.pop_front());
                    end
                end
            end
        end
    end

    task automatic set_readies(input int mode, input int k);
        case (mode)
            0: begin io_data_req_ready = 1'b1; io_release_ready = 1'b1; end
            1: begin io_data_req_ready = 1'b1; io_release_ready = !(k >= 3 && k <= 8); end
            2: begin io_data_req_ready = (k % 2 == 1); io_release_ready = 1'b1; end
            default: begin
                io_data_req_ready = ($urandom_range(0, 9) < 7);
                io_release_ready  = ($urandom_range(0, 9) < 7);
            end
        endcase
    endtask

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic send_req(input logic [5:0] idx, input logic [3:0] way, input logic [19:0] tag,
                            output int unsigned acc_cyc);
        int  w;
        bit  ok;
        io_req_valid       = 1'b1;
        io_req_bits_idx    = idx;
        io_req_bits_way_en = way;
        io_req_bits_tag    = tag;
        ok      = 1'b0;
        acc_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (io_req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL req_accept: got req_ready=0 for 100 cycles expected acceptance");
        end else begin
            acc_cyc = cyc;
            w = 0;
            for (int i = 3; i >= 0; i--) if (way[i]) w = i;
            for (int r = 0; r < 4; r++) begin
                exp_rds.push_back('{addr: {idx, 2'(r), 4'h0}, way: way});
                exp_beats.push_back('{data: mem[w][{idx, 2'(r)}], beat: 2'(r),
                                      last: (r == 3), tag: tag});
            end
        end
        @(negedge clk);
        io_req_valid = 1'b0;
    endtask

    task automatic run_line(input logic [5:0] idx, input logic [3:0] way, input logic [19:0] tag,
                            input int mode, input bit check_lat);
        int unsigned acc, rd0;
        bit done;
        set_readies(mode, 0);
        rd0 = rd_fire_total;
        send_req(idx, way, tag, acc);
        done = 1'b0;
        for (int k = 1; k < 300; k++) begin
            set_readies(mode, k);
            #1;
            if (check_lat) begin
                chk("lat_rd_valid", 128'(io_data_req_valid), 128'(k >= 1 && k <= 4));
                chk("lat_rel_valid", 128'(io_release_valid), 128'(k >= 3 && k <= 6));
                chk("lat_req_ready", 128'(io_req_ready), 128'(k == 7));
            end
            if (mode == 1 && k == 8) begin
                chk("stall_rd_count", 128'(rd_fire_total - rd0), 128'(3));
                chk("stall_rd_valid", 128'(io_data_req_valid), 128'(0));
            end
            if (!io_busy) begin done = 1'b1; break; end
            @(negedge clk);
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL line_done: got busy for 300 cycles expected return to idle");
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned a0, a1, a2;
        for (int w = 0; w < 4; w++)
            for (int j = 0; j < 256; j++) mem[w][j] = rnd128();
        for (int r = 0; r < 4; r++) mem[2][{6'h2A, 2'(r)}] = {4{32'hA0 + r}};

        // Reset with a request held high: must not be accepted.
        reset = 1'b1;
        io_req_valid = 1'b1; io_req_bits_idx = 6'h11; io_req_bits_way_en = 4'b0001;
        io_req_bits_tag = 20'h55555;
        io_data_req_ready = 1'b1; io_release_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0; io_req_valid = 1'b0;
        #1;
        chk("rst_busy", 128'(io_busy), 128'(0));
        chk("rst_req_ready", 128'(io_req_ready), 128'(1));
        chk("rst_rd_valid", 128'(io_data_req_valid), 128'(0));
        chk("rst_rel_valid", 128'(io_release_valid), 128'(0));
        @(negedge clk);

        // Nominal line with exact latency checks.
        run_line(6'h2A, 4'b0100, 20'h00A5A, 0, 1'b1);
        // Release back-pressure.
        run_line(6'h2A, 4'b0100, 20'h00A5A, 1, 1'b0);
        // Read-grant toggling.
        run_line(6'h15, 4'b0010, 20'h31337, 2, 1'b0);

        // Reset in the cycle after beat 1 fires.
        set_readies(0, 0);
        send_req(6'h07, 4'b1000, 20'hBEEF0, a0);
        for (int k = 1; k < 5; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 128'(io_busy), 128'(0));
        chk("midrst_rel_valid", 128'(io_release_valid), 128'(0));
        chk("midrst_req_ready", 128'(io_req_ready), 128'(1));
        @(negedge clk);
        run_line(6'h07, 4'b1000, 20'hBEEF0, 0, 1'b1);

        // Back-to-back requests: each next one accepted exactly 7 cycles later.
        set_readies(0, 0);
        send_req(6'h01, 4'b0001, 20'h12345, a0);
        send_req(6'h3F, 4'b0010, 20'h0ABCD, a1);
        send_req(6'h20, 4'b1000, 20'hFFFFF, a2);
        chk("b2b_accept_1", 128'(a1 - a0), 128'(7));
        chk("b2b_accept_2", 128'(a2 - a1), 128'(7));
        for (int k = 0; k < 20; k++) @(negedge clk);

        // Randomized lines and handshakes.
        for (int n = 0; n < 24; n++) begin
            logic [3:0] way;
            way = 4'b0001 << $urandom_range(0, 3);
            run_line(6'($urandom), way, 20'($urandom), 3, 1'b0);
        end

        for (int k = 0; k < 5; k++) @(negedge clk);
        #3;
        chk("sb_beats_drained", 128'(exp_beats.size()), 128'(0));
        chk("sb_reads_drained", 128'(exp_rds.size()), 128'(0));
        chk("final_idle", 128'(io_busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
